// File: rtl/nav_pkg.sv
// Shared definitions for the maze-robot navigation block: heading codes
// (same encoding as the movement block), FSM states and rotation helpers.
package nav_pkg;

  localparam logic [2:0] ORI_N = 3'b001;
  localparam logic [2:0] ORI_O = 3'b010;
  localparam logic [2:0] ORI_L = 3'b011;
  localparam logic [2:0] ORI_S = 3'b100;

  localparam int TIMEOUT_MOV_PAD = 15;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    AVALIA    = 3'd1,
    AVANCA    = 3'd2,
    CONCLUIDO = 3'd3,
    ERRO      = 3'd4
  } estado_t;

  // Left turn: N -> O -> S -> L -> N
  function automatic logic [2:0] gira_esq(input logic [2:0] o);
    case (o)
      ORI_N:   return ORI_O;
      ORI_O:   return ORI_S;
      ORI_S:   return ORI_L;
      default: return ORI_N;
    endcase
  endfunction

  // Right turn: N -> L -> S -> O -> N
  function automatic logic [2:0] gira_dir(input logic [2:0] o);
    case (o)
      ORI_N:   return ORI_L;
      ORI_L:   return ORI_S;
      ORI_S:   return ORI_O;
      default: return ORI_N;
    endcase
  endfunction

endpackage

// File: rtl/temporizador_mov.sv
// Movement watchdog: loadable down-counter. Loaded when a step is requested,
// counts down while enabled, and flags expiry when it reaches zero.
module temporizador_mov #(
  parameter int W_TMO = 4
) (
  input  logic             clockc3,
  input  logic             reset,
  input  logic             limpa,
  input  logic             carrega,
  input  logic             habilita,
  input  logic [W_TMO-1:0] valor,
  output logic             expirou
);

  logic [W_TMO-1:0] tmo;

  // Load on step start, clear when idle, otherwise count down to zero
  always_ff @(posedge clockc3) begin
    if (reset)                      tmo <= '0;
    else if (carrega)               tmo <= valor;
    else if (limpa)                 tmo <= '0;
    else if (habilita && tmo != '0) tmo <= tmo - 1'b1;
  end

  assign expirou = habilita && (tmo == '0);

endmodule

// File: rtl/controle_navegacao.sv
// Left-hand wall-follower sequencer. Optional step counter / step-limit abort
// is enabled by defining CONTADOR_PASSOS_EN.
module controle_navegacao
  import nav_pkg::*;
#(
`ifdef CONTADOR_PASSOS_EN
  parameter int MAX_PASSOS  = 255,
  parameter int W_PASSOS    = 8,
`endif
  parameter int TIMEOUT_MOV = TIMEOUT_MOV_PAD
) (
  input  logic       clockc3,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parede_frente,
  input  logic       parede_esq,
  input  logic       chegou,
  input  logic       mov_ok,
  output logic       avancar,
  output logic [2:0] orientacao,
  output logic       ocupado,
  output logic       fim,
  output logic       erro
`ifdef CONTADOR_PASSOS_EN
  ,
  output logic [W_PASSOS-1:0] passos
`endif
);

  localparam int W_TMO = (TIMEOUT_MOV > 1) ? $clog2(TIMEOUT_MOV) : 1;

  estado_t    estado, proximo;
  logic [2:0] ori_r;
  logic [1:0] giros;
  logic       reinicia, gira_e, gira_d, passo_ok;
  logic       limite, expirou, carrega_tmo;

`ifdef CONTADOR_PASSOS_EN
  assign limite = (passos == W_PASSOS'(MAX_PASSOS - 1));
`else
  assign limite = 1'b0;
`endif

  // State register
  always_ff @(posedge clockc3) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state decision and the per-edge actions that go with it
  always_comb begin
    proximo  = estado;
    reinicia = 1'b0;
    gira_e   = 1'b0;
    gira_d   = 1'b0;
    passo_ok = 1'b0;
    case (estado)
      OCIOSO, CONCLUIDO, ERRO: begin
        if (iniciar) begin
          proximo  = AVALIA;
          reinicia = 1'b1;
        end
      end
      AVALIA: begin
        if (chegou) begin
          proximo = CONCLUIDO;
        end else if (!parede_esq) begin
          gira_e  = 1'b1;
          proximo = AVANCA;
        end else if (!parede_frente) begin
          proximo = AVANCA;
        end else if (giros == 2'd3) begin
          proximo = ERRO;
        end else begin
          gira_d  = 1'b1;
        end
      end
      AVANCA: begin
        // mov_ok wins over a simultaneous timeout
        if (mov_ok) begin
          passo_ok = 1'b1;
          proximo  = limite ? ERRO : AVALIA;
        end else if (expirou) begin
          proximo  = ERRO;
        end
      end
      default: proximo = OCIOSO;
    endcase
  end

  // Heading and consecutive right-turn counter
  always_ff @(posedge clockc3) begin
    if (reset || reinicia) begin
      ori_r <= ORI_N;
      giros <= 2'd0;
    end else begin
      if (gira_e) begin
        ori_r <= gira_esq(ori_r);
      end else if (gira_d) begin
        ori_r <= gira_dir(ori_r);
        giros <= giros + 2'd1;
      end
      if (passo_ok) giros <= 2'd0;
    end
  end

`ifdef CONTADOR_PASSOS_EN
  // Completed-step counter, saturating at the limit
  always_ff @(posedge clockc3) begin
    if (reset || reinicia)                                  passos <= '0;
    else if (passo_ok && passos != W_PASSOS'(MAX_PASSOS))   passos <= passos + 1'b1;
  end
`endif

  assign carrega_tmo = (estado == AVALIA) && (proximo == AVANCA);

  temporizador_mov #(
    .W_TMO(W_TMO)
  ) u_tmo (
    .clockc3 (clockc3),
    .reset   (reset),
    .limpa   (estado != AVANCA),
    .carrega (carrega_tmo),
    .habilita(estado == AVANCA),
    .valor   (W_TMO'(TIMEOUT_MOV - 1)),
    .expirou (expirou)
  );

  // Outputs decoded from registered state only
  always_comb begin
    avancar    = (estado == AVANCA);
    ocupado    = (estado == AVALIA) || (estado == AVANCA);
    fim        = (estado == CONCLUIDO);
    erro       = (estado == ERRO);
    orientacao = ori_r;
  end

endmodule

// File: tb/tb_controle_navegacao.sv
// Bench for controle_navegacao: directed scenarios plus a randomized run
// against a behavioural model kept in heading-index / mode terms.
module tb_controle_navegacao;

  localparam int TMO  = 15;
  localparam int MAXP = 3;
  localparam int WP   = 8;
`ifdef CONTADOR_PASSOS_EN
  localparam int LIM  = MAXP;
`else
  localparam int LIM  = 32'h7fffffff;
`endif

  localparam int M_OC = 0, M_AV = 1, M_MV = 2, M_FIM = 3, M_ERR = 4;

  logic clockc3 = 1'b0;
  logic reset = 1'b1, iniciar = 1'b0, parede_frente = 1'b1, parede_esq = 1'b1;
  logic chegou = 1'b0, mov_ok = 1'b0;
  logic avancar, ocupado, fim, erro;
  logic [2:0] orientacao;
`ifdef CONTADOR_PASSOS_EN
  logic [WP-1:0] passos;
`endif

  int erros  = 0;
  int checks = 0;

  // heading index: 0 N, 1 O, 2 S, 3 L  (left turn = +1)
  logic [2:0] cod [4] = '{3'b001, 3'b010, 3'b100, 3'b011};
  int m_modo = M_OC, m_h = 0, m_giros = 0, m_passos = 0, m_tm = 0;

  always #5 clockc3 = ~clockc3;

  controle_navegacao #(
`ifdef CONTADOR_PASSOS_EN
    .MAX_PASSOS(MAXP),
    .W_PASSOS(WP),
`endif
    .TIMEOUT_MOV(TMO)
  ) dut (
    .clockc3(clockc3), .reset(reset), .iniciar(iniciar),
    .parede_frente(parede_frente), .parede_esq(parede_esq),
    .chegou(chegou), .mov_ok(mov_ok), .avancar(avancar),
    .orientacao(orientacao), .ocupado(ocupado), .fim(fim), .erro(erro)
`ifdef CONTADOR_PASSOS_EN
    , .passos(passos)
`endif
  );

  task automatic model_step();
    if (reset) begin
      m_modo = M_OC; m_h = 0; m_giros = 0; m_passos = 0; m_tm = 0;
    end else begin
      case (m_modo)
        M_OC, M_FIM, M_ERR:
          if (iniciar) begin
            m_modo = M_AV; m_h = 0; m_giros = 0; m_passos = 0;
          end
        M_AV:
          if (chegou) m_modo = M_FIM;
          else if (!parede_esq) begin m_h = (m_h + 1) % 4; m_modo = M_MV; m_tm = 0; end
          else if (!parede_frente) begin m_modo = M_MV; m_tm = 0; end
          else if (m_giros == 3) m_modo = M_ERR;
          else begin m_h = (m_h + 3) % 4; m_giros++; end
        M_MV:
          if (mov_ok) begin
            m_giros = 0;
            if (m_passos < LIM) m_passos++;
            m_modo = (m_passos == LIM) ? M_ERR : M_AV;
          end else if (m_tm == TMO - 1) m_modo = M_ERR;
          else m_tm++;
        default: m_modo = M_OC;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clockc3);
    model_step();
    #1;
  endtask

  task automatic quieto();
    iniciar = 0; chegou = 0; mov_ok = 0; parede_esq = 1; parede_frente = 1;
  endtask

  task automatic do_reset();
    quieto(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    quieto(); reset = 1; iniciar = 1; tick(); iniciar = 0;
    checks++;
    if ({avancar, orientacao, ocupado, fim, erro} !== 7'b0_001_000) begin
      erros++; $display("FAIL reset_outputs: got %b required %b", {avancar, orientacao, ocupado, fim, erro}, 7'b0_001_000);
    end
`ifdef CONTADOR_PASSOS_EN
    checks++;
    if (passos !== '0) begin erros++; $display("FAIL reset_passos: got %0d required 0", passos); end
`endif
    reset = 0;
  endtask

  task automatic test_esquerda();
    int n;
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    checks++;
    if ({ocupado, avancar} !== 2'b10) begin erros++; $display("FAIL start_latency: got ocupado,avancar=%b required 10", {ocupado, avancar}); end
    parede_esq = 0; tick(); parede_esq = 1;
    checks++;
    if ({avancar, orientacao} !== 4'b1_010) begin erros++; $display("FAIL left_turn: got %b required 1010", {avancar, orientacao}); end
    n = int'(avancar);
    iniciar = 1; tick(); iniciar = 0; n += int'(avancar);
    checks++;
    if ({avancar, orientacao} !== 4'b1_010) begin erros++; $display("FAIL iniciar_ignored: got %b required 1010", {avancar, orientacao}); end
    tick(); n += int'(avancar);
    mov_ok = 1; tick(); mov_ok = 0; n += int'(avancar);
    checks++;
    if (n !== 3) begin erros++; $display("FAIL avancar_cycles: got %0d required 3", n); end
    checks++;
    if ({avancar, ocupado, orientacao} !== 5'b01_010) begin erros++; $display("FAIL after_step: got %b required 01010", {avancar, ocupado, orientacao}); end
`ifdef CONTADOR_PASSOS_EN
    checks++;
    if (passos !== 8'd1) begin erros++; $display("FAIL passos_one: got %0d required 1", passos); end
`endif
  endtask

  task automatic test_frente_chegada();
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    parede_frente = 0; tick(); parede_frente = 1;
    checks++;
    if ({avancar, orientacao} !== 4'b1_001) begin erros++; $display("FAIL straight: got %b required 1001", {avancar, orientacao}); end
    mov_ok = 1; tick(); mov_ok = 0;
    chegou = 1; tick(); chegou = 0;
    checks++;
    if ({fim, ocupado, erro} !== 3'b100) begin erros++; $display("FAIL goal: got fim,ocupado,erro=%b required 100", {fim, ocupado, erro}); end
    tick();
    checks++;
    if (fim !== 1'b1) begin erros++; $display("FAIL goal_sticky: got %b required 1", fim); end
  endtask

  task automatic test_cercado();
    logic [2:0] esp [3];
    esp = '{3'b011, 3'b100, 3'b010};
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({orientacao, avancar, erro} !== {esp[i], 2'b00}) begin
        erros++; $display("FAIL enclosed_turn%0d: got %b required %b", i, {orientacao, avancar, erro}, {esp[i], 2'b00});
      end
    end
    tick();
    checks++;
    if ({erro, ocupado, orientacao} !== 5'b10_010) begin erros++; $display("FAIL enclosed_abort: got %b required 10010", {erro, ocupado, orientacao}); end
    iniciar = 1; tick(); iniciar = 0;
    checks++;
    if ({ocupado, erro, orientacao} !== 5'b10_001) begin erros++; $display("FAIL restart_from_erro: got %b required 10001", {ocupado, erro, orientacao}); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    parede_esq = 0; tick(); parede_esq = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!avancar) break;
      n++; tick();
    end
    checks++;
    if (n !== TMO) begin erros++; $display("FAIL timeout_len: got %0d required %0d", n, TMO); end
    checks++;
    if (erro !== 1'b1) begin erros++; $display("FAIL timeout_erro: got %b required 1", erro); end
  endtask

  task automatic test_timeout_ok();
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    parede_esq = 0; tick(); parede_esq = 1;
    for (int i = 1; i < TMO; i++) tick();
    checks++;
    if (avancar !== 1'b1) begin erros++; $display("FAIL last_cycle_avancar: got %b required 1", avancar); end
    mov_ok = 1; tick(); mov_ok = 0;
    checks++;
    if ({erro, ocupado, avancar} !== 3'b010) begin erros++; $display("FAIL late_mov_ok: got erro,ocupado,avancar=%b required 010", {erro, ocupado, avancar}); end
  endtask

  task automatic test_reset_meio();
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    parede_esq = 0; tick(); parede_esq = 1;
    checks++;
    if (avancar !== 1'b1) begin erros++; $display("FAIL pre_reset_avancar: got %b required 1", avancar); end
    reset = 1; iniciar = 1; mov_ok = 1; tick(); reset = 0; iniciar = 0; mov_ok = 0;
    checks++;
    if ({avancar, orientacao, ocupado} !== 5'b0_001_0) begin erros++; $display("FAIL mid_step_reset: got %b required 00010", {avancar, orientacao, ocupado}); end
  endtask

`ifdef CONTADOR_PASSOS_EN
  task automatic test_limite();
    do_reset();
    iniciar = 1; tick(); iniciar = 0;
    parede_frente = 0; mov_ok = 1;
    for (int i = 0; i < 50; i++) begin
      if (erro) break;
      tick();
    end
    mov_ok = 0; parede_frente = 1;
    checks++;
    if ({erro, passos} !== {1'b1, 8'd3}) begin erros++; $display("FAIL step_limit: got erro=%b passos=%0d required erro=1 passos=3", erro, passos); end
    iniciar = 1; tick(); iniciar = 0;
    checks++;
    if ({ocupado, passos} !== {1'b1, 8'd0}) begin erros++; $display("FAIL limit_restart: got ocupado=%b passos=%0d required 1 0", ocupado, passos); end
  endtask
`endif

  task automatic test_aleatorio();
    logic [6:0] esp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      iniciar       = ($urandom_range(0, 9) == 0);
      chegou        = ($urandom_range(0, 15) == 0);
      parede_esq    = ($urandom_range(0, 2) != 0);
      parede_frente = ($urandom_range(0, 1) != 0);
      mov_ok        = ($urandom_range(0, 7) < ((c / 500) % 2 == 0 ? 3 : 0));
      tick();
      esp = {m_modo == M_MV, cod[m_h], (m_modo == M_AV) || (m_modo == M_MV), m_modo == M_FIM, m_modo == M_ERR};
      checks++;
      if ({avancar, orientacao, ocupado, fim, erro} !== esp) begin
        erros++; $display("FAIL random_c%0d: got %b required %b", c, {avancar, orientacao, ocupado, fim, erro}, esp);
      end
`ifdef CONTADOR_PASSOS_EN
      checks++;
      if (passos !== WP'(m_passos)) begin erros++; $display("FAIL random_passos_c%0d: got %0d required %0d", c, passos, m_passos); end
`endif
    end
    quieto(); reset = 0;
  endtask

  initial begin
    test_reset();
    test_esquerda();
    test_frente_chegada();
    test_cercado();
    test_timeout();
    test_timeout_ok();
    test_reset_meio();
`ifdef CONTADOR_PASSOS_EN
    test_limite();
`endif
    test_aleatorio();
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
